alu_sequencer: RTL and testbench
================================

// Module: alu_sequencer
// PURPOSE
//  Initiator side of the ALU operand/strobe interface. Accepts one decoded ALU-class
//  instruction (valid/ready), reads dst/src from the register file, drives op1/op2/instr/
//  opt/PSW into the ALU, pulses the ALU enable, then writes the result and the PSW back.
//  Sits between the decode stage and the register file; it owns the architectural PSW.
// PARAMETERS
//  DATA_W   16       operand/result/PSW width
//  REG_AW   3        register-file index width (8 registers)
//  PSW_RST  16'h0000 PSW value after reset
// PORTS
//  clk            in   1       system clock, all logic on rising edge
//  rst            in   1       synchronous, active-high reset
//  req_valid      in   1       request present
//  req_ready      out  1       sequencer can accept (IDLE only)
//  req_opcode     in   6       ALU instr code; legal range 6'h00..6'h1B
//  req_dst_idx    in   REG_AW  dst register (op1, written back)
//  req_src_idx    in   REG_AW  src register (op2)
//  req_use_const  in   1       1: op2 = req_const instead of src register
//  req_const      in   DATA_W  constant operand
//  req_psw_upd    in   1       forwarded to ALU instr_opt
//  rf_rd_addr_a   out  REG_AW  read port A address (dst)
//  rf_rd_addr_b   out  REG_AW  read port B address (src)
//  rf_rd_data_a   in   DATA_W  port A data, valid 1 cycle after address
//  rf_rd_data_b   in   DATA_W  port B data, valid 1 cycle after address
//  alu_op1        out  DATA_W  dst operand; alu_op2 out DATA_W src operand
//  alu_instr      out  6       opcode to ALU;  alu_opt out 1 = latched req_psw_upd
//  alu_psw_i      out  DATA_W  current PSW to ALU
//  alu_e          out  1       ALU enable strobe, one-cycle high pulse
//  alu_result     in   DATA_W  ALU result;  alu_psw_o in DATA_W ALU flags out
//  rf_wr_en       out  1       register write strobe (1 cycle)
//  rf_wr_addr     out  REG_AW  write address;  rf_wr_data out DATA_W write data
//  psw_ld         in   1       external PSW write (e.g. SETCC);  psw_ld_data in DATA_W
//  psw            out  DATA_W  architectural PSW
//  done           out  1       one-cycle completion pulse;  err out 1 = illegal opcode, with done
// BEHAVIOUR
//  - Reset: state IDLE; req_ready=1; alu_e, rf_wr_en, done, err=0; psw=PSW_RST; all
//    latched operand/opcode/address registers 0. Reset wins over every other event,
//    including mid-operation: in-flight op abandoned, no rf write, no PSW update.
//  - All outputs registered. Handshake: accept when req_valid&&req_ready in IDLE; all
//    req_* latched that cycle; req_* ignored in every other state.
//  - FSM (T0 = accept cycle):
//    IDLE -> READ (legal opcode) / ERR (opcode > 6'h1B).
//    READ (T1): rf_rd_addr_a=dst, rf_rd_addr_b=src; -> OPER.
//    OPER (T2): latch op1=rf_rd_data_a, op2=use_const?const:rf_rd_data_b; -> ISSUE.
//    ISSUE (T3): alu_e=1, op1/op2/instr/opt/psw_i stable from T3 until WB; -> CAPT.
//    CAPT (T4): alu_e=0; sample alu_result, alu_psw_o; -> WB.
//    WB (T5): rf_wr_en=1 unless opcode in {cmp 0A, cmp.b 0B, bit 12, bit.b 13};
//      rf_wr_addr=dst, rf_wr_data=result (full 16 b; ALU merges byte-op upper half);
//      psw<=alu_psw_o; done=1; -> IDLE.
//    ERR (T1): done=1, err=1, no alu_e, no rf write, PSW unchanged; -> IDLE.
//  - Throughput: legal op accept->done 5 cycles, next accept earliest T6.
//  - PSW: psw_ld in any state loads psw_ld_data; if coincident with WB, psw_ld wins and
//    ALU flags are discarded (rf write still occurs). alu_psw_i snapshot taken in OPER.
//  - dst==src allowed: both ports read same register. dst updated only in WB.
// TESTING (bench supplies 8x16 RF model and behavioural ALU responding on alu_e rise)
//  1 Reset: rst=1 one cycle -> req_ready=1, alu_e=0, rf_wr_en=0, done=0, psw=16'h0000.
//  2 add (00) R2=0x0003 dst, R1=0x0005 src -> alu_e at T3 with op1=0x0003, op2=0x0005;
//    T5 rf_wr_en=1, addr=2, data=0x0008, done=1, exactly one alu_e pulse.
//  3 cmp (0A) R0=R1=0x1234, psw_upd=1 -> no rf_wr_en; T5 psw[1](Z)=1, psw[0](C)=1.
//  4 opcode 6'h20 -> T1 done=1, err=1; alu_e never high; rf_wr_en=0; psw unchanged.
//  5 rst=1 during CAPT of an add -> no rf_wr_en, psw=PSW_RST, req_ready=1 next cycle.
//  6 psw_ld=1, data=0x00F0 in WB of sub; req_valid held high while busy -> psw=0x00F0,
//    rf write occurs; second request accepted only at T6 (not T1..T5).

Source files
------------

// File: rtl/alu_sequencer.sv
// alu_sequencer
//   Initiator side of the ALU operand/strobe interface. Takes one decoded
//   ALU-class instruction, reads dst/src from the register file, presents the
//   operands, opcode, option bit and current PSW to the ALU, pulses alu_e, then
//   writes the result and the returned flags back. Owns the architectural PSW.
//
//   State   | Meaning
//   --------+-------------------------------------------------------------
//   S_IDLE  | ready for a request (req_ready=1)
//   S_READ  | register-file read addresses presented (T1)
//   S_OPER  | read data arrives; operands and PSW snapshot latched (T2)
//   S_ISSUE | alu_e high for one cycle (T3)
//   S_CAPT  | ALU result and flags sampled (T4)
//   S_WB    | rf write strobe + done; PSW commits at the end of this cycle (T5)
//   S_ERR   | illegal opcode: done+err, nothing else happens (T1)
//
// Ports
//   clk, rst                      clock, synchronous active-high reset
//   req_valid / req_ready         request handshake (accept only in S_IDLE)
//   req_opcode, req_dst_idx, req_src_idx, req_use_const, req_const,
//   req_psw_upd                   request payload, latched on accept
//   rf_rd_addr_a/b, rf_rd_data_a/b  register-file read ports (1-cycle latency)
//   alu_op1, alu_op2, alu_instr, alu_opt, alu_psw_i, alu_e   to the ALU
//   alu_result, alu_psw_o         from the ALU
//   rf_wr_en, rf_wr_addr, rf_wr_data  register-file write port
//   psw_ld, psw_ld_data           external PSW load, highest priority
//   psw                           architectural PSW
//   done, err                     completion pulse, illegal-opcode flag
module alu_sequencer #(
    parameter int                DATA_W  = 16,
    parameter int                REG_AW  = 3,
    parameter logic [DATA_W-1:0] PSW_RST = 16'h0000
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic [5:0]        req_opcode,
    input  logic [REG_AW-1:0] req_dst_idx,
    input  logic [REG_AW-1:0] req_src_idx,
    input  logic              req_use_const,
    input  logic [DATA_W-1:0] req_const,
    input  logic              req_psw_upd,
    output logic [REG_AW-1:0] rf_rd_addr_a,
    output logic [REG_AW-1:0] rf_rd_addr_b,
    input  logic [DATA_W-1:0] rf_rd_data_a,
    input  logic [DATA_W-1:0] rf_rd_data_b,
    output logic [DATA_W-1:0] alu_op1,
    output logic [DATA_W-1:0] alu_op2,
    output logic [5:0]        alu_instr,
    output logic              alu_opt,
    output logic [DATA_W-1:0] alu_psw_i,
    output logic              alu_e,
    input  logic [DATA_W-1:0] alu_result,
    input  logic [DATA_W-1:0] alu_psw_o,
    output logic              rf_wr_en,
    output logic [REG_AW-1:0] rf_wr_addr,
    output logic [DATA_W-1:0] rf_wr_data,
    input  logic              psw_ld,
    input  logic [DATA_W-1:0] psw_ld_data,
    output logic [DATA_W-1:0] psw,
    output logic              done,
    output logic              err
);

    localparam logic [5:0] OP_MAX = 6'h1B;

    typedef enum logic [2:0] {
        S_IDLE,
        S_READ,
        S_OPER,
        S_ISSUE,
        S_CAPT,
        S_WB,
        S_ERR
    } state_t;

    state_t state, state_nxt;

    logic              accept;
    logic              illegal;
    logic              no_wb;
    logic              use_const_q;
    logic [DATA_W-1:0] const_q;
    logic [DATA_W-1:0] psw_capt;

    assign accept  = (state == S_IDLE) && req_valid;
    assign illegal = (req_opcode > OP_MAX);

    // Compare and bit-test only produce flags; their result is not written back.
    always_comb begin
        no_wb = 1'b0;
        case (alu_instr)
            6'h0A, 6'h0B, 6'h12, 6'h13: no_wb = 1'b1;
            default:                    no_wb = 1'b0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE:  if (accept) state_nxt = illegal ? S_ERR : S_READ;
            S_READ:  state_nxt = S_OPER;
            S_OPER:  state_nxt = S_ISSUE;
            S_ISSUE: state_nxt = S_CAPT;
            S_CAPT:  state_nxt = S_WB;
            S_WB:    state_nxt = S_IDLE;
            S_ERR:   state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
    end

    // Every output is a flop; strobes are decoded from the next state so they
    // line up with the state they belong to.
    always_ff @(posedge clk) begin
        if (rst) begin
            req_ready    <= 1'b1;
            alu_e        <= 1'b0;
            rf_wr_en     <= 1'b0;
            done         <= 1'b0;
            err          <= 1'b0;
            rf_rd_addr_a <= '0;
            rf_rd_addr_b <= '0;
            rf_wr_addr   <= '0;
            rf_wr_data   <= '0;
            alu_op1      <= '0;
            alu_op2      <= '0;
            alu_instr    <= '0;
            alu_opt      <= 1'b0;
            alu_psw_i    <= '0;
            use_const_q  <= 1'b0;
            const_q      <= '0;
            psw_capt     <= '0;
            psw          <= PSW_RST;
        end else begin
            req_ready <= (state_nxt == S_IDLE);
            alu_e     <= (state_nxt == S_ISSUE);
            rf_wr_en  <= (state == S_CAPT) && !no_wb;
            done      <= (state == S_CAPT) || (accept && illegal);
            err       <= accept && illegal;

            if (accept) begin
                rf_rd_addr_a <= req_dst_idx;
                rf_rd_addr_b <= req_src_idx;
                rf_wr_addr   <= req_dst_idx;
                alu_instr    <= req_opcode;
                alu_opt      <= req_psw_upd;
                use_const_q  <= req_use_const;
                const_q      <= req_const;
            end

            if (state == S_OPER) begin
                alu_op1   <= rf_rd_data_a;
                alu_op2   <= use_const_q ? const_q : rf_rd_data_b;
                alu_psw_i <= psw;
            end

            if (state == S_CAPT) begin
                rf_wr_data <= alu_result;
                psw_capt   <= alu_psw_o;
            end

            // An external load beats the ALU flags, even in the writeback cycle.
            if (psw_ld) begin
                psw <= psw_ld_data;
            end else if (state == S_WB) begin
                psw <= psw_capt;
            end
        end
    end

endmodule

// File: tb/tb_alu_sequencer.sv
// tb_alu_sequencer
//   Self-checking bench for alu_sequencer. Provides an 8x16 register file with
//   one-cycle read latency, a behavioural ALU that responds to alu_e, and a
//   cycle-count model of one request (cycles since accept) that predicts every
//   output each cycle. Directed tests add literal expectations.
module tb_alu_sequencer;

    localparam int DATA_W = 16;
    localparam int REG_AW = 3;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic              req_valid = 1'b0;
    logic              req_ready;
    logic [5:0]        req_opcode = '0;
    logic [REG_AW-1:0] req_dst_idx = '0;
    logic [REG_AW-1:0] req_src_idx = '0;
    logic              req_use_const = 1'b0;
    logic [DATA_W-1:0] req_const = '0;
    logic              req_psw_upd = 1'b0;
    logic [REG_AW-1:0] rf_rd_addr_a, rf_rd_addr_b;
    logic [DATA_W-1:0] rf_rd_data_a = '0;
    logic [DATA_W-1:0] rf_rd_data_b = '0;
    logic [DATA_W-1:0] alu_op1, alu_op2, alu_psw_i;
    logic [5:0]        alu_instr;
    logic              alu_opt, alu_e;
    logic [DATA_W-1:0] alu_result = '0;
    logic [DATA_W-1:0] alu_psw_o = '0;
    logic              rf_wr_en;
    logic [REG_AW-1:0] rf_wr_addr;
    logic [DATA_W-1:0] rf_wr_data;
    logic              psw_ld = 1'b0;
    logic [DATA_W-1:0] psw_ld_data = '0;
    logic [DATA_W-1:0] psw;
    logic              done, err;

    alu_sequencer #(.DATA_W(DATA_W), .REG_AW(REG_AW), .PSW_RST(16'h0000)) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_opcode(req_opcode), .req_dst_idx(req_dst_idx), .req_src_idx(req_src_idx),
        .req_use_const(req_use_const), .req_const(req_const), .req_psw_upd(req_psw_upd),
        .rf_rd_addr_a(rf_rd_addr_a), .rf_rd_addr_b(rf_rd_addr_b),
        .rf_rd_data_a(rf_rd_data_a), .rf_rd_data_b(rf_rd_data_b),
        .alu_op1(alu_op1), .alu_op2(alu_op2), .alu_instr(alu_instr), .alu_opt(alu_opt),
        .alu_psw_i(alu_psw_i), .alu_e(alu_e),
        .alu_result(alu_result), .alu_psw_o(alu_psw_o),
        .rf_wr_en(rf_wr_en), .rf_wr_addr(rf_wr_addr), .rf_wr_data(rf_wr_data),
        .psw_ld(psw_ld), .psw_ld_data(psw_ld_data), .psw(psw),
        .done(done), .err(err)
    );

    always #5 clk = ~clk;

    int n_pass = 0;
    int n_total = 0;
    int alu_e_cnt = 0;
    logic check_en = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    endtask

    // Reference ALU: add, subtract-like (sub/cmp), everything else XOR.
    // Flags when opt=1: bit1 Z, bit0 C (carry / no-borrow); upper PSW bits kept.
    function automatic logic [31:0] alu_ref(input logic [5:0] op, input logic [15:0] a,
                                            input logic [15:0] b, input logic [15:0] pi,
                                            input logic opt);
        logic [16:0] s;
        logic [15:0] f;
        if (op == 6'h00)                                  s = {1'b0, a} + {1'b0, b};
        else if (op == 6'h01 || op == 6'h0A || op == 6'h0B) s = {1'b0, a} + {1'b0, ~b} + 17'd1;
        else                                              s = {1'b0, a ^ b};
        f = opt ? {pi[15:2], (s[15:0] == 16'h0), s[16]} : pi;
        return {f, s[15:0]};
    endfunction

    // Register file and preload port
    logic [15:0] rf [8] = '{default: 16'h0};
    logic        pl_en = 1'b0;
    logic [2:0]  pl_idx = '0;
    logic [15:0] pl_val = '0;

    always @(posedge clk) begin
        rf_rd_data_a <= rf[rf_rd_addr_a];
        rf_rd_data_b <= rf[rf_rd_addr_b];
        if (rf_wr_en) rf[rf_wr_addr] <= rf_wr_data;
        if (pl_en) rf[pl_idx] <= pl_val;
    end

    always @(posedge clk) begin
        logic [31:0] r;
        if (alu_e) begin
            r = alu_ref(alu_instr, alu_op1, alu_op2, alu_psw_i, alu_opt);
            alu_result <= r[15:0];
            alu_psw_o  <= r[31:16];
        end
    end

    // Model: phase = cycles since accept (0 = idle).
    int          phase = 0;
    logic        m_legal = 1'b0, m_wr = 1'b0, m_opt = 1'b0;
    logic [5:0]  m_op = '0;
    logic [2:0]  m_dst = '0, m_src = '0;
    logic [15:0] m_op1 = '0, m_op2 = '0, m_res = '0, m_flags = '0, m_psw = '0, m_psw_i = '0;
    logic [15:0] m_rf [8] = '{default: 16'h0};

    always @(posedge clk) begin
        logic [15:0] nxt_psw;
        logic [31:0] r;
        if (rst) begin
            phase = 0;
            m_psw = 16'h0000;
        end else begin
            nxt_psw = m_psw;
            if (phase == 0) begin
                if (req_valid) begin
                    m_op    = req_opcode;
                    m_dst   = req_dst_idx;
                    m_src   = req_src_idx;
                    m_opt   = req_psw_upd;
                    m_legal = (req_opcode <= 6'h1B);
                    m_wr    = !(req_opcode inside {6'h0A, 6'h0B, 6'h12, 6'h13});
                    m_op1   = m_rf[req_dst_idx];
                    m_op2   = req_use_const ? req_const : m_rf[req_src_idx];
                    phase   = 1;
                end
            end else if (phase == 1 && !m_legal) begin
                phase = 0;
            end else if (phase == 2) begin
                m_psw_i = m_psw;
                r       = alu_ref(m_op, m_op1, m_op2, m_psw_i, m_opt);
                m_res   = r[15:0];
                m_flags = r[31:16];
                phase   = 3;
            end else if (phase == 5) begin
                if (m_wr) m_rf[m_dst] = m_res;
                nxt_psw = m_flags;
                phase   = 0;
            end else begin
                phase = phase + 1;
            end
            if (psw_ld) nxt_psw = psw_ld_data;
            m_psw = nxt_psw;
            if (pl_en) m_rf[pl_idx] = pl_val;
        end
    end

    always @(negedge clk) begin
        if (alu_e) alu_e_cnt++;
        if (check_en) begin
            chk("req_ready", req_ready, phase == 0);
            chk("alu_e", alu_e, phase == 3 && m_legal);
            chk("rf_wr_en", rf_wr_en, phase == 5 && m_legal && m_wr);
            chk("done", done, (phase == 5 && m_legal) || (phase == 1 && !m_legal));
            chk("err", err, phase == 1 && !m_legal);
            chk("psw", psw, m_psw);
            if (phase == 1 && m_legal) begin
                chk("rd_addr_a", rf_rd_addr_a, m_dst);
                chk("rd_addr_b", rf_rd_addr_b, m_src);
            end
            if (phase >= 3 && phase <= 5 && m_legal) begin
                chk("alu_op1", alu_op1, m_op1);
                chk("alu_op2", alu_op2, m_op2);
                chk("alu_instr", alu_instr, m_op);
                chk("alu_opt", alu_opt, m_opt);
                chk("alu_psw_i", alu_psw_i, m_psw_i);
            end
            if (phase == 5 && m_legal && m_wr) begin
                chk("wr_addr", rf_wr_addr, m_dst);
                chk("wr_data", rf_wr_data, m_res);
            end
        end
    end

    task automatic run(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic preload(input logic [2:0] idx, input logic [15:0] val);
        pl_en = 1'b1; pl_idx = idx; pl_val = val;
        run(1);
        pl_en = 1'b0;
    endtask

    task automatic set_req(input logic [5:0] op, input logic [2:0] d, input logic [2:0] s,
                           input logic uc, input logic [15:0] cv, input logic upd);
        req_opcode = op; req_dst_idx = d; req_src_idx = s;
        req_use_const = uc; req_const = cv; req_psw_upd = upd;
    endtask

    // Presents a request in an idle cycle; returns 1 ns into T1.
    task automatic issue(input logic [5:0] op, input logic [2:0] d, input logic [2:0] s,
                         input logic uc, input logic [15:0] cv, input logic upd);
        set_req(op, d, s, uc, cv, upd);
        req_valid = 1'b1;
        run(1);
        req_valid = 1'b0;
    endtask

    logic [5:0] ops [6] = '{6'h0B, 6'h12, 6'h13, 6'h1B, 6'h1C, 6'h3F};
    int e0;

    initial begin
        // Reset state
        run(1);
        rst = 1'b0;
        chk("rst req_ready", req_ready, 1'b1);
        chk("rst alu_e", alu_e, 1'b0);
        chk("rst rf_wr_en", rf_wr_en, 1'b0);
        chk("rst done", done, 1'b0);
        chk("rst psw", psw, 16'h0000);
        check_en = 1'b1;

        // add R2(3) + R1(5)
        preload(3'd2, 16'h0003);
        preload(3'd1, 16'h0005);
        e0 = alu_e_cnt;
        issue(6'h00, 3'd2, 3'd1, 1'b0, 16'h0, 1'b0);
        run(2);
        chk("add T3 alu_e", alu_e, 1'b1);
        chk("add T3 op1", alu_op1, 16'h0003);
        chk("add T3 op2", alu_op2, 16'h0005);
        run(2);
        chk("add T5 wr_en", rf_wr_en, 1'b1);
        chk("add T5 wr_addr", rf_wr_addr, 3'd2);
        chk("add T5 wr_data", rf_wr_data, 16'h0008);
        chk("add T5 done", done, 1'b1);
        run(1);
        chk("add alu_e pulses", alu_e_cnt - e0, 1);

        // dst == src: xor R2 with itself
        issue(6'h05, 3'd2, 3'd2, 1'b0, 16'h0, 1'b0);
        run(5);
        chk("xor self R2", rf[2], 16'h0000);

        // cmp equal values with flag update
        preload(3'd0, 16'h1234);
        preload(3'd1, 16'h1234);
        issue(6'h0A, 3'd0, 3'd1, 1'b0, 16'h0, 1'b1);
        run(4);
        chk("cmp T5 wr_en", rf_wr_en, 1'b0);
        chk("cmp T5 done", done, 1'b1);
        run(1);
        chk("cmp psw", psw, 16'h0003);

        // illegal opcode
        e0 = alu_e_cnt;
        issue(6'h20, 3'd1, 3'd2, 1'b0, 16'h0, 1'b1);
        chk("ill done", done, 1'b1);
        chk("ill err", err, 1'b1);
        run(1);
        chk("ill psw", psw, 16'h0003);
        chk("ill ready", req_ready, 1'b1);
        run(4);
        chk("ill alu_e pulses", alu_e_cnt - e0, 0);

        // reset during CAPT of an add
        preload(3'd4, 16'h0100);
        preload(3'd5, 16'h0011);
        issue(6'h00, 3'd4, 3'd5, 1'b0, 16'h0, 1'b1);
        run(3);
        rst = 1'b1;
        run(1);
        rst = 1'b0;
        chk("abort wr_en", rf_wr_en, 1'b0);
        chk("abort ready", req_ready, 1'b1);
        chk("abort psw", psw, 16'h0000);
        run(3);
        chk("abort R4", rf[4], 16'h0100);

        // sub with psw_ld in WB, request held high while busy
        preload(3'd6, 16'h0050);
        preload(3'd7, 16'h0010);
        preload(3'd3, 16'h0FFF);
        set_req(6'h01, 3'd6, 3'd7, 1'b0, 16'h0, 1'b1);
        req_valid = 1'b1;
        run(1);
        set_req(6'h00, 3'd3, 3'd0, 1'b1, 16'h7000, 1'b1);
        run(4);
        chk("sub T5 wr_en", rf_wr_en, 1'b1);
        psw_ld = 1'b1; psw_ld_data = 16'h00F0;
        run(1);
        psw_ld = 1'b0;
        chk("sub psw_ld", psw, 16'h00F0);
        chk("sub T6 ready", req_ready, 1'b1);
        run(1);
        req_valid = 1'b0;
        chk("2nd accepted", rf_rd_addr_a, 3'd3);
        chk("2nd busy", req_ready, 1'b0);
        run(6);
        chk("sub R6", rf[6], 16'h0040);
        chk("const add R3", rf[3], 16'h7FFF);
        chk("final psw", psw, 16'h00F0);

        // opcode table: no-writeback ops and legal/illegal boundary
        for (int i = 0; i < 6; i++) begin
            issue(ops[i], 3'(i), 3'(i + 3), 1'(i), 16'(i * 16'h00A5), 1'b1);
            run(6);
        end
        run(2);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
